// File: rtl/tilt_pkg.sv
// Shared defaults and the in-flight tag record for the tilt-unit arbiter.
// Every tag is a valid bit plus the id of the requester that owns the operation.
package tilt_pkg;
  localparam int TILT_NREQ    = 4;
  localparam int TILT_LATENCY = 5;
  localparam int TILT_RES_W   = 2;
  localparam int TILT_ID_W    = $clog2(TILT_NREQ);

  typedef struct packed {
    logic                 valid;
    logic [TILT_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: the search starts at ptr and wraps modulo NREQ.
// No grant is given while en is low.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant
);

  logic           w_found;
  logic [IDW-1:0] w_idx;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(ptr) + k) % NREQ);
      if (en && !w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tilt_arbiter.sv
// Shares one fixed-latency tilt unit among NREQ requesters; a tag shift register
// tracks which requester owns each in-flight operation and routes the result back.
module tilt_arbiter
  import tilt_pkg::*;
#(
  parameter int NREQ    = TILT_NREQ,
  parameter int LATENCY = TILT_LATENCY,
  parameter int RES_W   = TILT_RES_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_dataa,
  input  logic [NREQ*32-1:0]   req_datab,
  input  logic [NREQ-1:0]      req_datac,
  output logic                 unit_clk_en,
  output logic [31:0]          unit_dataa,
  output logic [31:0]          unit_datab,
  output logic                 unit_datac,
  input  logic [RES_W-1:0]     unit_result,
  output logic [NREQ-1:0]      resp_valid,
  output logic [RES_W-1:0]     resp_result,
  output logic                 busy
);

  localparam int ID_W = TILT_ID_W;

  logic            w_en;
  logic [NREQ-1:0] w_grant;
  logic            w_any_grant;
  logic [ID_W-1:0] w_grant_id;
  tag_t            w_tag_out;
  logic [ID_W-1:0] r_rr_ptr;
  tag_t            r_tag [1:LATENCY];

  // Reset also blocks issue so nothing is accepted while tags are being cleared.
  assign w_en        = !hold && !reset;
  assign unit_clk_en = !hold;

  rr_arbiter #(.NREQ(NREQ), .IDW(ID_W)) u_rr (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .en    (w_en),
    .grant (w_grant)
  );

  assign req_ready   = w_grant;
  assign w_any_grant = |w_grant;

  always_comb begin
    w_grant_id = '0;
    unit_dataa = '0;
    unit_datab = '0;
    unit_datac = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_grant_id = ID_W'(i);
        unit_dataa = req_dataa[32*i +: 32];
        unit_datab = req_datab[32*i +: 32];
        unit_datac = req_datac[i];
      end
    end
  end

  // Issue stage -> tag pipeline; stage LATENCY lines up with unit_result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      for (int s = 1; s <= LATENCY; s++) r_tag[s] <= '0;
    end else if (w_en) begin
      r_tag[1] <= '{valid: w_any_grant, id: w_grant_id};
      for (int s = 2; s <= LATENCY; s++) r_tag[s] <= r_tag[s-1];
      if (w_any_grant)
        r_rr_ptr <= (w_grant_id == ID_W'(NREQ - 1)) ? '0 : w_grant_id + ID_W'(1);
    end
  end

  assign w_tag_out = r_tag[LATENCY];

  always_comb begin
    resp_valid = '0;
    busy       = 1'b0;
    for (int i = 0; i < NREQ; i++)
      resp_valid[i] = w_tag_out.valid && !hold && (w_tag_out.id == ID_W'(i));
    for (int s = 1; s <= LATENCY; s++) busy = busy | r_tag[s].valid;
  end

  assign resp_result = (|resp_valid) ? unit_result : '0;

endmodule

// File: doc/tilt_arbiter.md
TILT_ARBITER -- requirements
Module: tilt_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one tilt unit.
REQ-002 Parameter LATENCY, default 5, fixed tilt-unit latency in enabled cycles; legal range 1..31.
REQ-003 Parameter RES_W, default 2, tilt result width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 hold  in  1  global stall; freezes issue and pipeline.
REQ-007 req_valid  in  NREQ  per-requester operation request.
REQ-008 req_ready  out  NREQ  one-hot grant; operands accepted this cycle.
REQ-009 req_dataa, req_datab  in  NREQ*32  flattened operands, requester i at bits [32i+31:32i].
REQ-010 req_datac  in  NREQ  per-requester mode bit.
REQ-011 unit_clk_en  out  1  tilt-unit enable, equal to ~hold.
REQ-012 unit_dataa, unit_datab  out  32  muxed operands of granted requester, zero when no grant.
REQ-013 unit_datac  out  1  muxed mode bit, zero when no grant.
REQ-014 unit_result  in  RES_W  tilt-unit result.
REQ-015 resp_valid  out  NREQ  one-cycle one-hot pulse, result for requester i.
REQ-016 resp_result  out  RES_W  unit_result when any resp_valid is high, else zero.
REQ-017 busy  out  1  high while any issued operation has not yet returned.

Function
REQ-018 Arbitration SHALL be round-robin: search starts at rr_ptr, and rr_ptr becomes (granted index + 1) mod NREQ after each grant.
REQ-019 At most one grant per cycle; req_ready SHALL be combinational from req_valid, rr_ptr and hold.
REQ-020 With hold=1: req_ready=0, unit_clk_en=0, resp_valid=0, tag pipeline and rr_ptr frozen.
REQ-021 Each grant SHALL push {valid=1, id} into a LATENCY-deep tag shift register; a non-grant enabled cycle pushes valid=0.
REQ-022 An operation granted in enabled cycle T SHALL produce resp_valid[id]=1 in the cycle where its tag reaches stage LATENCY, i.e. after exactly LATENCY enabled cycles.
REQ-023 Back-to-back grants SHALL be accepted every enabled cycle; responses SHALL return in issue order, one per cycle.
REQ-024 A requester MAY hold multiple operations in flight; each returns separately in order.
REQ-025 busy SHALL be the OR of all tag valid bits.
REQ-026 Requests with req_valid deasserted before grant SHALL be dropped silently; no response is issued.

Reset
REQ-027 Reset SHALL clear all tag valid bits and set rr_ptr=0 asynchronously.
REQ-028 During and immediately after reset: req_ready=0 while reset high, resp_valid=0, busy=0, resp_result=0.
REQ-029 Reset mid-operation SHALL discard in-flight tags; no response is issued for them, even if unit_result later changes.

Structure
REQ-030 Shared package tilt_pkg SHALL hold the defaults for NREQ, LATENCY and RES_W, plus the tag record type {valid, id[$clog2(NREQ)-1:0]}.
REQ-031 Round-robin grant logic SHALL be the sub-module rr_arbiter (inputs: req, ptr, en; output: one-hot grant).

Verification
REQ-032 Single request: req_valid=0001 for one cycle, LATENCY=5 -> req_ready=0001 at cycle 0, resp_valid=0001 at cycle 5, busy high for cycles 1-5.
REQ-033 All-request fairness: req_valid=1111 held for 8 cycles from rr_ptr=0 -> grants 0,1,2,3,0,1,2,3 and responses in the same order at cycles 5-12.
REQ-034 Hold: hold=1 for 3 cycles starting at cycle 2 after a grant at cycle 0 -> resp_valid is delayed to cycle 8 and unit_clk_en=0 for those 3 cycles.
REQ-035 Reset mid-flight: grants at cycles 0-2, reset pulse at cycle 3 -> no resp_valid afterward, busy=0, next grant goes to requester 0.
REQ-036 Operand mux: requester 2 with dataa=0x1234, datab=0xABCD, datac=1 granted -> unit_dataa/unit_datab/unit_datac equal these values that cycle and are zero on idle cycles.
